// File: rtl/skin_pkg.sv
// Shared definitions for the skin sensor scan path: channel count, select width
// and the scan sequencer state encoding.
package skin_pkg;

  localparam int unsigned NCH   = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

endpackage

// File: rtl/skin_scan_sample_vote.sv
// Per-channel sample counter and ones counter with threshold compare; vote
// includes the sample presented on the last cycle.
module sample_vote #(
  parameter int unsigned N_SAMPLES = 4,
  parameter int unsigned THRESH    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic y_in,
  output logic last,
  output logic vote
);

  localparam int unsigned CW = $clog2(N_SAMPLES + 1);

  logic [CW-1:0] samp_cnt_q;
  logic [CW-1:0] ones_q;
  logic [CW:0]   ones_total;

  assign last       = en && (samp_cnt_q == CW'(N_SAMPLES - 1));
  assign ones_total = {1'b0, ones_q} + (CW + 1)'(y_in);
  assign vote       = ones_total >= (CW + 1)'(THRESH);

  // Counters clear themselves on the last sample so they never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_cnt_q <= '0;
      ones_q     <= '0;
    end else if (clr || last) begin
      samp_cnt_q <= '0;
      ones_q     <= '0;
    end else if (en) begin
      samp_cnt_q <= samp_cnt_q + 1'b1;
      ones_q     <= ones_q + CW'(y_in);
    end
  end

endmodule

// File: rtl/skin_scan.sv
// Scan sequencer for the 8-channel skin sensor mux: settle, majority-vote each
// channel, then hand the assembled frame downstream over valid/ready.
module skin_scan
  import skin_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned N_SAMPLES     = 4,
  parameter int unsigned THRESH        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             y_in,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [NCH-1:0]   frame,
  output logic             frame_valid,
  input  logic             frame_ready
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

  state_e           state_q;
  logic [SW-1:0]    settle_q;
  logic [SEL_W-1:0] sel_q;
  logic [NCH-1:0]   shadow_q;
  logic [NCH-1:0]   frame_q;
  logic             frame_valid_q;

  logic vote_en;
  logic vote_clr;
  logic vote_last;
  logic vote;

  assign vote_en  = (state_q == StSample);
  assign vote_clr = ((state_q == StIdle) && start) ||
                    ((state_q == StDone) && frame_ready && continuous);

  sample_vote #(
    .N_SAMPLES (N_SAMPLES),
    .THRESH    (THRESH)
  ) u_sample_vote (
    .clk  (clk),
    .rst  (rst),
    .clr  (vote_clr),
    .en   (vote_en),
    .y_in (y_in),
    .last (vote_last),
    .vote (vote)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      settle_q      <= '0;
      sel_q         <= '0;
      shadow_q      <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StSettle;
            settle_q <= '0;
            sel_q    <= '0;
            shadow_q <= '0;
          end
        end
        StSettle: begin
          if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
            settle_q <= '0;
            state_q  <= StSample;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        StSample: begin
          if (vote_last) begin
            shadow_q[sel_q] <= vote;
            if (sel_q != SEL_W'(NCH - 1)) begin
              sel_q   <= sel_q + 1'b1;
              state_q <= StSettle;
            end else begin
              // Last channel's vote bypasses the shadow so the frame is complete now.
              frame_q       <= {vote, shadow_q[NCH-2:0]};
              frame_valid_q <= 1'b1;
              state_q       <= StDone;
            end
          end
        end
        StDone: begin
          if (frame_ready) begin
            frame_valid_q <= 1'b0;
            sel_q         <= '0;
            settle_q      <= '0;
            shadow_q      <= '0;
            state_q       <= continuous ? StSettle : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sel         = sel_q;
  assign busy        = (state_q != StIdle);
  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;

endmodule
